// File: rtl/hash_candidate_feeder.sv
// Candidate sweeper feeding hollywood_hash: serializes each candidate, watches hash_hit for a
// fixed window and captures the first hit. Optional pause input when FEEDER_PAUSE_EN is defined.
module hash_candidate_feeder #(
  parameter int          NUM_WORDS   = 2,
  parameter int          WAIT_CYCLES = 8,
  parameter logic [31:0] START_VAL   = 32'h0000_0000,
  parameter logic [31:0] LAST_VAL    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef FEEDER_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        hash_hit,
  output logic        in_valid,
  output logic        in_channel,
  output logic [15:0] in_data,
  output logic        busy,
  output logic        found,
  output logic [31:0] found_cand,
  output logic        exhausted
);

  if (NUM_WORDS < 1 || NUM_WORDS > 2) begin : g_bad_num_words
    $error("NUM_WORDS must be 1 or 2");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait_cycles
    $error("WAIT_CYCLES must be in 1..255");
  end
  if (START_VAL > LAST_VAL) begin : g_bad_range
    $error("START_VAL must not exceed LAST_VAL");
  end
  if (NUM_WORDS == 1 && LAST_VAL > 32'h0000_FFFF) begin : g_bad_last
    $error("LAST_VAL does not fit in NUM_WORDS 16-bit words");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_TERM  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FOUND = 3'd4;
  localparam logic [2:0] S_EXH   = 3'd5;

  localparam logic        IDX_LAST  = (NUM_WORDS == 2) ? 1'b1 : 1'b0;
  localparam logic [7:0]  WIN_LAST  = 8'(WAIT_CYCLES - 1);
  localparam logic [15:0] TERM_WORD = 16'(NUM_WORDS);

  logic        pause_w;
`ifdef FEEDER_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  logic [2:0]  state_q, state_d;
  logic        idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cand_q, cand_d;
  logic        in_valid_q, in_valid_d;
  logic        in_channel_q, in_channel_d;
  logic [15:0] in_data_q, in_data_d;
  logic        busy_q, busy_d;
  logic        found_q, found_d;
  logic [31:0] found_cand_q, found_cand_d;
  logic        exhausted_q, exhausted_d;
  logic        fresh;
  logic        emit_slot;

  // State names the word slot on the bus; in_valid_q says whether it was actually presented,
  // so a paused slot is held and re-offered until it goes out.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    found_d      = found_q;
    found_cand_d = found_cand_q;
    exhausted_d  = exhausted_q;
    fresh        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          idx_d   = 1'b0;
          fresh   = 1'b1;
        end
      end
      S_SEND: begin
        if (in_valid_q) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_TERM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_TERM: begin
        if (in_valid_q) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        if (hash_hit) begin
          state_d      = S_FOUND;
          found_d      = 1'b1;
          found_cand_d = cand_q;
        end else if (cnt_q == WIN_LAST) begin
          if (cand_q == LAST_VAL) begin
            state_d     = S_EXH;
            exhausted_d = 1'b1;
          end else begin
            cand_d  = cand_q + 32'd1;
            state_d = S_SEND;
            idx_d   = 1'b0;
            fresh   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FOUND: begin
        if (start) begin
          found_d = 1'b0;
          if (found_cand_q == LAST_VAL) begin
            state_d     = S_EXH;
            exhausted_d = 1'b1;
          end else begin
            cand_d  = found_cand_q + 32'd1;
            state_d = S_SEND;
            idx_d   = 1'b0;
            fresh   = 1'b1;
          end
        end
      end
      S_EXH: begin
        if (start) begin
          exhausted_d = 1'b0;
          cand_d      = START_VAL;
          state_d     = S_SEND;
          idx_d       = 1'b0;
          fresh       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Word 0 always goes out on entry; pause only stalls slots already inside SEND/TERM.
    emit_slot    = (state_d == S_SEND) || (state_d == S_TERM);
    in_valid_d   = emit_slot && (fresh || !pause_w);
    in_channel_d = in_valid_d && (state_d == S_TERM);
    in_data_d    = 16'd0;
    if (in_valid_d) begin
      if (state_d == S_TERM) begin
        in_data_d = TERM_WORD;
      end else begin
        in_data_d = idx_d ? cand_d[31:16] : cand_d[15:0];
      end
    end
    busy_d = emit_slot || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 1'b0;
      cnt_q        <= 8'd0;
      cand_q       <= START_VAL;
      in_valid_q   <= 1'b0;
      in_channel_q <= 1'b0;
      in_data_q    <= 16'd0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      found_cand_q <= 32'd0;
      exhausted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      in_valid_q   <= in_valid_d;
      in_channel_q <= in_channel_d;
      in_data_q    <= in_data_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      found_cand_q <= found_cand_d;
      exhausted_q  <= exhausted_d;
    end
  end

  assign in_valid   = in_valid_q;
  assign in_channel = in_channel_q;
  assign in_data    = in_data_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign found_cand = found_cand_q;
  assign exhausted  = exhausted_q;

endmodule

// File: tb/tb_hash_candidate_feeder.sv
// Bench for hash_candidate_feeder: two instances (2-word and 1-word) checked every cycle against
// a slot/window level model, plus directed literal pins and a randomized phase.
module tb_hash_candidate_feeder;

  localparam logic [31:0] SV0 = 32'h0001_2344;
  localparam logic [31:0] LV0 = 32'h0001_234B;
  localparam logic [31:0] SV1 = 32'h0000_FFFE;
  localparam logic [31:0] LV1 = 32'h0000_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, st0, st1, ht0, ht1, pz0, pz1;
  logic v0, ch0, bz0, fd0, ex0;
  logic v1, ch1, bz1, fd1, ex1;
  logic [15:0] d0, d1;
  logic [31:0] fc0, fc1;

  int checks = 0;
  int errors = 0;

  hash_candidate_feeder #(
    .NUM_WORDS(2), .WAIT_CYCLES(8), .START_VAL(SV0), .LAST_VAL(LV0)
  ) u_dut0 (
    .clk(clk), .reset(rst0), .start(st0),
`ifdef FEEDER_PAUSE_EN
    .pause(pz0),
`endif
    .hash_hit(ht0), .in_valid(v0), .in_channel(ch0), .in_data(d0),
    .busy(bz0), .found(fd0), .found_cand(fc0), .exhausted(ex0)
  );

  hash_candidate_feeder #(
    .NUM_WORDS(1), .WAIT_CYCLES(4), .START_VAL(SV1), .LAST_VAL(LV1)
  ) u_dut1 (
    .clk(clk), .reset(rst1), .start(st1),
`ifdef FEEDER_PAUSE_EN
    .pause(pz1),
`endif
    .hash_hit(ht1), .in_valid(v1), .in_channel(ch1), .in_data(d1),
    .busy(bz1), .found(fd1), .found_cand(fc1), .exhausted(ex1)
  );

  // ---------------- reference model ----------------
  // md: 0 idle, 1 emitting slots, 2 result window, 3 hit held, 4 exhausted
  int          md  [2];
  int          pos [2];   // slots already presented for the current candidate
  int          win [2];   // window cycles elapsed
  logic [31:0] mc  [2];
  logic [31:0] mfc [2];
  logic        mf  [2];
  logic        mx  [2];
  logic        ev  [2];
  logic        ech [2];
  logic [15:0] ed  [2];
  bit          armed = 1'b0;

  function automatic int nw(input int u);
    return (u == 0) ? 2 : 1;
  endfunction
  function automatic int wc(input int u);
    return (u == 0) ? 8 : 4;
  endfunction
  function automatic logic [31:0] sv(input int u);
    return (u == 0) ? SV0 : SV1;
  endfunction
  function automatic logic [31:0] lv(input int u);
    return (u == 0) ? LV0 : LV1;
  endfunction

  task automatic present(input int u);
    ev[u]  = 1'b1;
    ech[u] = (pos[u] == nw(u));
    ed[u]  = (pos[u] == nw(u)) ? 16'(nw(u)) : 16'(mc[u] >> (16 * pos[u]));
    pos[u] = pos[u] + 1;
  endtask

  task automatic launch(input int u);
    md[u]  = 1;
    pos[u] = 0;
    present(u);
  endtask

  task automatic mstep(input int u, input logic r, input logic s, input logic h, input logic p);
    ev[u]  = 1'b0;
    ech[u] = 1'b0;
    ed[u]  = 16'd0;
    if (r) begin
      md[u] = 0; pos[u] = 0; win[u] = 0;
      mc[u] = sv(u); mfc[u] = 32'd0; mf[u] = 1'b0; mx[u] = 1'b0;
      return;
    end
    case (md[u])
      0: if (s) launch(u);
      1: begin
        if (pos[u] == nw(u) + 1) begin
          md[u] = 2; win[u] = 0;
        end else if (!p) begin
          present(u);
        end
      end
      2: begin
        if (h) begin
          md[u] = 3; mf[u] = 1'b1; mfc[u] = mc[u];
        end else if (win[u] == wc(u) - 1) begin
          if (mc[u] == lv(u)) begin
            md[u] = 4; mx[u] = 1'b1;
          end else begin
            mc[u] = mc[u] + 32'd1;
            launch(u);
          end
        end else begin
          win[u] = win[u] + 1;
        end
      end
      3: begin
        if (s) begin
          mf[u] = 1'b0;
          if (mfc[u] == lv(u)) begin
            md[u] = 4; mx[u] = 1'b1;
          end else begin
            mc[u] = mfc[u] + 32'd1;
            launch(u);
          end
        end
      end
      4: begin
        if (s) begin
          mx[u] = 1'b0; mc[u] = sv(u);
          launch(u);
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mstep(0, rst0, st0, ht0, pz0);
      mstep(1, rst1, st1, ht1, pz1);
      armed = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int u, input int k);
    logic [31:0] r;
    r = 32'd0;
    case (k)
      0: r = 32'((u == 0) ? v0 : v1);
      1: r = 32'((u == 0) ? ch0 : ch1);
      2: r = 32'((u == 0) ? d0 : d1);
      3: r = 32'((u == 0) ? bz0 : bz1);
      4: r = 32'((u == 0) ? fd0 : fd1);
      5: r = (u == 0) ? fc0 : fc1;
      default: r = 32'((u == 0) ? ex0 : ex1);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] expv(input int u, input int k);
    logic [31:0] r;
    r = 32'd0;
    case (k)
      0: r = 32'(ev[u]);
      1: r = 32'(ech[u]);
      2: r = 32'(ed[u]);
      3: r = 32'(md[u] == 1 || md[u] == 2);
      4: r = 32'(mf[u]);
      5: r = mfc[u];
      default: r = 32'(mx[u]);
    endcase
    return r;
  endfunction

  function automatic string sname(input int k);
    case (k)
      0: return "in_valid";
      1: return "in_channel";
      2: return "in_data";
      3: return "busy";
      4: return "found";
      5: return "found_cand";
      default: return "exhausted";
    endcase
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        for (int k = 0; k < 7; k++) begin
          chk($sformatf("model u%0d %s", u, sname(k)), obs(u, k), expv(u, k));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_term(input int u, input int lim);
    int n;
    n = 0;
    while (!((u == 0) ? (v0 && ch0) : (v1 && ch1)) && n < lim) begin
      tick();
      n++;
    end
    chk($sformatf("wait_term u%0d reached", u), 32'((u == 0) ? (v0 && ch0) : (v1 && ch1)), 32'd1);
  endtask

  initial begin
    int nterm;
    rst0 = 1'b1; rst1 = 1'b1;
    st0 = 1'b0; st1 = 1'b0; ht0 = 1'b0; ht1 = 1'b0; pz0 = 1'b0; pz1 = 1'b0;
    tick(); tick(); tick();
    chk("reset in_valid", 32'(v0), 32'd0);
    chk("reset busy", 32'(bz0), 32'd0);
    chk("reset found", 32'(fd0), 32'd0);
    chk("reset found_cand", fc0, 32'd0);
    chk("reset exhausted", 32'(ex1), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // Word sequence and candidate period
    st0 = 1'b1; tick(); st0 = 1'b0;
    chk("s1 w0 valid", 32'(v0), 32'd1);
    chk("s1 w0 ch", 32'(ch0), 32'd0);
    chk("s1 w0 data", 32'(d0), 32'h2344);
    tick();
    chk("s1 w1 data", 32'(d0), 32'h0001);
    tick();
    chk("s1 term ch", 32'(ch0), 32'd1);
    chk("s1 term data", 32'(d0), 32'h0002);
    repeat (9) tick();
    chk("s1 next w0 valid", 32'(v0), 32'd1);
    chk("s1 next w0 data", 32'(d0), 32'h2345);

    // Hit three cycles after the terminator of 0x0001_2345
    wait_term(0, 20);
    tick(); tick(); tick();
    ht0 = 1'b1; tick(); ht0 = 1'b0;
    chk("s2 found", 32'(fd0), 32'd1);
    chk("s2 found_cand", fc0, 32'h0001_2345);
    chk("s2 busy", 32'(bz0), 32'd0);
    repeat (5) begin
      ht0 = 1'($urandom_range(0, 1));
      tick();
      chk("s2 hold in_valid", 32'(v0), 32'd0);
    end
    ht0 = 1'b0;

    // Resume after a hit; hit on the final window cycle captures
    st0 = 1'b1; tick(); st0 = 1'b0;
    chk("s4 found cleared", 32'(fd0), 32'd0);
    chk("s4 w0 data", 32'(d0), 32'h2346);
    tick();
    chk("s4 w1 data", 32'(d0), 32'h0001);
    wait_term(0, 5);
    repeat (8) tick();
    chk("s4 last window busy", 32'(bz0), 32'd1);
    ht0 = 1'b1; tick(); ht0 = 1'b0;
    chk("s4 found", 32'(fd0), 32'd1);
    chk("s4 found_cand", fc0, 32'h0001_2346);
    chk("s4 no advance", 32'(v0), 32'd0);

    // Reset during the terminator; busy start ignored
    st0 = 1'b1; tick(); st0 = 1'b0;
    wait_term(0, 5);
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    chk("s5 in_valid", 32'(v0), 32'd0);
    chk("s5 busy", 32'(bz0), 32'd0);
    chk("s5 found_cand", fc0, 32'd0);
    tick();
    st0 = 1'b1; tick(); st0 = 1'b0;
    chk("s5 restart data", 32'(d0), 32'h2344);
    st0 = 1'b1; tick(); st0 = 1'b0;
    chk("s5 w1 data", 32'(d0), 32'h0001);
    tick();
    chk("s5 term", 32'(ch0), 32'd1);
    repeat (9) tick();
    chk("s5 next w0 data", 32'(d0), 32'h2345);

`ifdef FEEDER_PAUSE_EN
    pz0 = 1'b1;
    repeat (4) begin
      tick();
      chk("s6 paused in_valid", 32'(v0), 32'd0);
    end
    pz0 = 1'b0;
    tick();
    chk("s6 w1 valid", 32'(v0), 32'd1);
    chk("s6 w1 data", 32'(d0), 32'h0001);
    tick();
    chk("s6 term", 32'(ch0), 32'd1);
    pz0 = 1'b1; repeat (3) tick(); pz0 = 1'b0;
    repeat (6) tick();
    chk("s6 window not extended", 32'(d0), 32'h2346);
`endif

    // One-word instance: two terminators, then exhausted
    st1 = 1'b1; tick(); st1 = 1'b0;
    chk("s3 w0 data", 32'(d1), 32'hFFFE);
    nterm = 0;
    for (int i = 0; i < 30; i++) begin
      if (v1 && ch1) nterm++;
      tick();
    end
    chk("s3 terminator count", 32'(nterm), 32'd2);
    chk("s3 exhausted", 32'(ex1), 32'd1);
    chk("s3 busy", 32'(bz1), 32'd0);
    st1 = 1'b1; tick(); st1 = 1'b0;
    chk("s3 exhausted cleared", 32'(ex1), 32'd0);
    chk("s3 restart data", 32'(d1), 32'hFFFE);
    wait_term(1, 10);
    tick();
    wait_term(1, 10);
    tick();
    ht1 = 1'b1; tick(); ht1 = 1'b0;
    chk("s3 found_cand last", fc1, 32'h0000_FFFF);
    st1 = 1'b1; tick(); st1 = 1'b0;
    chk("s3 found cleared", 32'(fd1), 32'd0);
    chk("s3 last hit exhausts", 32'(ex1), 32'd1);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      st0  = ($urandom_range(0, 9) == 0);
      st1  = ($urandom_range(0, 9) == 0);
      ht0  = ($urandom_range(0, 19) == 0);
      ht1  = ($urandom_range(0, 19) == 0);
      rst0 = ($urandom_range(0, 299) == 0);
      rst1 = ($urandom_range(0, 299) == 0);
`ifdef FEEDER_PAUSE_EN
      pz0  = ($urandom_range(0, 3) == 0);
      pz1  = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end
    st0 = 1'b0; st1 = 1'b0; ht0 = 1'b0; ht1 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
    pz0 = 1'b0; pz1 = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_candidate_feeder.md
Name: hash_candidate_feeder

Overview:
- Upstream stage of hollywood_hash. Sweeps a counter of candidate inputs and serializes each candidate into the hash input stream (in_valid/in_channel/in_data).
- After each candidate it watches the hash out_valid (wired to hash_hit) for a fixed window. It captures the first candidate that produces a hit.
- Drives a brute-force search loop on the FPGA without a host in the loop.

Parameters:
- NUM_WORDS, 2: 16-bit words per candidate, legal range 1..2. Word k = cand[16k+15:16k], low word first.
- WAIT_CYCLES, 8: result window length in cycles after the terminator word, legal range 1..255.
- START_VAL, 32'h0000_0000: first candidate.
- LAST_VAL, 32'hFFFF_FFFF: last candidate, inclusive.
- Illegal values are an elaboration error. This includes START_VAL > LAST_VAL and LAST_VAL >= 2^(16*NUM_WORDS).

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or resumes the search.
- hash_hit  in  1  hash core out_valid.
- in_valid  out  1  word valid to hash core.
- in_channel  out  1  0 = candidate data word, 1 = terminator word.
- in_data  out  16  word payload.
- busy  out  1  high in SEND, TERM, WAIT.
- found  out  1  level; a hit has been captured.
- found_cand  out  32  candidate that hit.
- exhausted  out  1  level; LAST_VAL tried with no hit.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset loads cand = START_VAL and state = IDLE.
- Reset asserted mid-operation aborts the current candidate. in_valid is low the next cycle.

State machine: IDLE, SEND, TERM, WAIT, FOUND, EXHAUSTED.
- IDLE: start -> SEND, word index = 0.
- SEND, one word per cycle:
  - in_valid = 1, in_channel = 0, in_data = word[idx].
  - After word NUM_WORDS-1 -> TERM.
- TERM, one cycle:
  - in_valid = 1, in_channel = 1, in_data = 16'(NUM_WORDS).
  - -> WAIT, window counter = 0.
- WAIT: in_valid = 0. The counter increments each cycle.
  - hash_hit = 1 -> FOUND: found_cand = cand, found = 1.
  - Counter reaches WAIT_CYCLES-1 with no hit, and cand == LAST_VAL -> EXHAUSTED: exhausted = 1.
  - Counter reaches WAIT_CYCLES-1 with no hit, and cand != LAST_VAL -> cand+1, -> SEND.
  - A hit on the last window cycle wins over advancing.
- FOUND / EXHAUSTED: hold outputs; busy = 0.

Timing:
- start sampled at cycle t. Word 0 is valid at t+1. The terminator is at t+NUM_WORDS+1.
- The window covers t+NUM_WORDS+2 .. t+NUM_WORDS+1+WAIT_CYCLES.
- The next candidate's word 0 follows immediately, so the candidate period is NUM_WORDS+1+WAIT_CYCLES cycles.

Start rules:
- start while busy: ignored.
- start in FOUND: clears found (found_cand held).
  - found_cand == LAST_VAL -> EXHAUSTED the next cycle.
  - Otherwise cand = found_cand+1, -> SEND.
- start in EXHAUSTED: clears exhausted, cand = START_VAL, -> SEND.

Other boundaries:
- hash_hit outside WAIT: ignored, no state effect.
- Counter arithmetic: cand never increments past LAST_VAL, so there is no 32-bit wrap. The compare happens before the increment.

Optional Feature:
- Macro FEEDER_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit), placed after start.
  - While pause = 1 in SEND/TERM: in_valid = 0, and the word index and state are held. Emission resumes with the same word the cycle after pause drops.
  - In WAIT the window counter keeps running, since the hash is in flight.
  - pause has no effect in IDLE, FOUND, or EXHAUSTED.
- Not defined: no pause port; behaviour as above.

Test Plan:
1. Defaults; start at cycle 5; hash_hit tied 0 -> words at cycles 6–8.
   - Cycle 6: ch0 0x0000. Cycle 7: ch0 0x0000. Cycle 8: ch1 0x0002.
   - Candidate 1 word 0 at cycle 17 (period 11).
2. START_VAL = 0x0001_2344; model hash pulses hash_hit 3 cycles after the terminator of cand 0x0001_2345.
   - found = 1, found_cand = 0x0001_2345, busy = 0, in_valid stays 0.
3. NUM_WORDS = 1, START_VAL = 0xFFFE, LAST_VAL = 0xFFFF, no hits.
   - Exactly two terminators, then exhausted = 1.
   - Second start -> cand restarts at 0xFFFE and exhausted clears.
4. After scenario 2, pulse start.
   - found clears; next word 0 = 0x2346, word 1 = 0x0001.
   - Hit on the final window cycle (cycle 8 of 8) -> FOUND, not advance.
5. Reset asserted during TERM -> next cycle in_valid = 0 and all outputs 0.
   - The next start re-emits START_VAL.
   - start pulsed while busy has no effect on sequence timing.
6. FEEDER_PAUSE_EN: pause high for 4 cycles after word 0.
   - Word 1 and the terminator are delayed 4 cycles.
   - Pause during WAIT does not extend the 8-cycle window.
